down4bit_timer: RTL
===================

# down4bit_timer

Loadable down counter with start/pause control and a terminal-count pulse. It is the counting-down counterpart of the team's 4-bit positive-edge up counter. It serves as a programmable delay or event timer: software-style control loads a start value, launches the count, and receives a one-cycle `done` strobe when the count reaches zero.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `clk` in 1: clock. All state updates occur on the rising edge.
- `reset` in 1: asynchronous reset, active-high.
- `load` in 1: load `load_val` into `count` and into the reload register.
- `load_val` in `WIDTH`: value to load.
- `start` in 1: launch counting.
- `pause` in 1: freeze counting while running.
- `count` out `WIDTH`: current count, registered.
- `busy` out 1: high when the state is RUN or HOLD.
- `zero` out 1: combinational, equals (`count == 0`).
- `done` out 1: registered one-cycle terminal-count pulse.

## Operation
- States are IDLE, RUN, HOLD and DONE.
- Reset values:
  - state = IDLE
  - `count` = {WIDTH{1'b1}} (4'hF)
  - reload register = 4'hF
  - `done` = 0
  - `busy` = 0
- `load` priority: `load`=1 in any state causes `count` ← `load_val`, reload ← `load_val`, state ← IDLE and `done` ← 0. In that cycle `load` overrides `start` and `pause`.
- IDLE:
  - `start`=1 and `count`≠0 → RUN. There is no decrement on this edge.
  - `start`=1 with `count`=0 is ignored; the block stays in IDLE.
- RUN:
  - `pause`=1 → HOLD, and `count` holds.
  - `pause`=0 with `count`>1: `count` ← `count`−1.
  - `pause`=0 with `count`=1: `count` ← 0, `done` ← 1 for one cycle, state → DONE. The autoreload variant is described under Configuration.
- HOLD:
  - `count` is frozen.
  - `pause`=0 → RUN, with no decrement on that edge. Decrementing resumes on the following edge.
- DONE:
  - `count` holds 0.
  - `start`=1 → `count` ← reload and state → RUN, with no decrement on that edge. If reload = 0, `start` is ignored.
- `done` is 0 in every cycle other than the single cycle following the edge on which `count` reached 0.
- Arithmetic is modulo 2^WIDTH. `count` never wraps below 0 in RUN, because the transition at `count`=1 is handled explicitly.
- `start` and `pause` both high in IDLE: the block enters RUN, and `pause` takes effect on the next edge.

## Timing
- `load` at edge N: `count` = `load_val` from edge N.
- `start` accepted at edge N: `busy`=1 from edge N, and the first decrement occurs at edge N+1.
- Start-to-`done` latency for a run of value V with no pause is V edges after the `start` edge. `done` and `zero` rise together on edge N+V.
- Each HOLD episode of k cycles with `pause` high adds k+1 cycles to the latency.
- Asynchronous reset asserted mid-run: all outputs go to their reset values immediately, with no dependence on `clk`. After release, the block sits in IDLE with `count`=4'hF.

## Configuration
- Macro: `DOWN4BIT_TIMER_AUTORELOAD_EN`.
- Defined:
  - RUN at `count`=1 with `pause`=0 → `count` ← 0 and `done` pulses; the state stays RUN.
  - On the next unpaused RUN edge with `count`=0, `count` ← reload.
  - The sequence is periodic with period reload+1: V, …, 1, 0, V, …
  - DONE is unreachable in this variant.
  - Only `load` or `reset` stops the counter.
- Undefined: one-shot behaviour as described under Operation.

## Test plan
- **Reset:** assert `reset` for 10 ns with `clk` toggling at a 10 ns period → `count`=4'hF, `busy`=0, `done`=0 throughout. `zero`=0.
- **One-shot run:** `load_val`=3, `load` pulse, then `start` pulse at edge N → `count` reads 3 after edge N, 2 at N+1, 1 at N+2, 0 at N+3. `done`=1 only in the cycle after N+3; `busy` falls at N+3.
- **Pause:** load 5, start, then `pause`=1 for 3 cycles after `count`=3 → `count` stays 3 for 4 cycles. `done` fires 1 cycle + 3 cycles later than in the unpaused run.
- **Priority and edge cases:**
  - `load` with `load_val`=0 while in RUN → IDLE, `count`=0, `zero`=1, `busy`=0.
  - `start` is then ignored.
  - `load` and `start` in the same cycle → `load` wins and the state is IDLE.
- **Restart from DONE and async reset:**
  - After the run of 3 ends, `start` → `count`=3 and `busy`=1.
  - Then assert `reset` mid-count, between clock edges → `count`=4'hF immediately and `busy`=0.
- **Autoreload:** with `DOWN4BIT_TIMER_AUTORELOAD_EN` defined, load 2 and start → `count` sequence 2,1,0,2,1,0. `done` pulses every 3 cycles and `busy` stays 1.

Source files
------------

// File: rtl/down4bit_timer.sv
// down4bit_timer: loadable down counter with start/pause control and a
// one-cycle terminal-count strobe, usable as a programmable delay/event timer.
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   reset_i     asynchronous reset, active-high
//   load_i      load load_val_i into count and reload register (highest priority)
//   load_val_i  value to load (WIDTH bits)
//   start_i     launch counting (from IDLE, or restart from DONE)
//   pause_i     freeze counting while running
//   count_o     current count, registered
//   busy_o      high while RUN or HOLD
//   zero_o      combinational, count_o == 0
//   done_o      registered one-cycle terminal-count pulse
//
// Optional feature: define DOWN4BIT_TIMER_AUTORELOAD_EN for periodic
// operation (count wraps from 0 back to the reload value, DONE never entered).
// Latency: load/start take effect on the edge they are sampled; first
// decrement one edge after start; done rises V edges after start of value V.
// Backpressure: none; pause_i stalls the count, each pause episode of k
// cycles costs k+1 cycles because leaving HOLD does not decrement.

module down4bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             pause_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             zero_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ALL1 = {WIDTH{1'b1}};

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q,   done_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            count_q  <= CNT_ALL1;
            reload_q <= CNT_ALL1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load_i) begin
            // load overrides start/pause in every state
            count_d  = load_val_i;
            reload_d = load_val_i;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // entering RUN does not decrement; a zero count cannot start
                    if (start_i && (count_q != CNT_ZERO)) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause_i) begin
                        state_d = S_HOLD;
                    end else if (count_q == CNT_ONE) begin
                        // terminal step handled explicitly so count never wraps
                        count_d = CNT_ZERO;
                        done_d  = 1'b1;
`ifdef DOWN4BIT_TIMER_AUTORELOAD_EN
                        state_d = S_RUN;
`else
                        state_d = S_DONE;
`endif
                    end else if (count_q == CNT_ZERO) begin
`ifdef DOWN4BIT_TIMER_AUTORELOAD_EN
                        // the zero cycle closes the period, then reload
                        count_d = reload_q;
`else
                        // not reachable in one-shot mode; park safely
                        state_d = S_DONE;
`endif
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
                S_HOLD: begin
                    // resume without decrementing on this edge
                    if (!pause_i) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start_i && (reload_q != CNT_ZERO)) begin
                        count_d = reload_q;
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == S_RUN) || (state_q == S_HOLD);
    assign zero_o  = (count_q == CNT_ZERO);
    assign done_o  = done_q;

endmodule
